pkt_error_marker: RTL and testbench

Packet qualification stage placed directly upstream of the rollback FIFO. Accepts a raw beat stream with per-beat error and end-of-packet flags, and tracks packet length, sticky error and an optional XOR checksum. Emits each beat with `{tuser, tlast, payload}` packed into the FIFO's data word: `tlast & tuser` on the final beat rolls the packet back, and `tlast & ~tuser` commits it. Oversize packets are truncated into a marked-bad packet, and their remainder is swallowed.

---
 rtl/pkt_error_marker_pkg.sv | 16 +
 rtl/pkt_error_marker_if.sv | 26 ++
 rtl/pkt_error_marker_out_reg.sv | 31 +++
 rtl/pkt_error_marker.sv | 137 +++++++++++++
 tb/tb_pkt_error_marker.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_error_marker_pkg.sv
// Shared types and constants for the packet error marker.
// Consumers import pkt_marker_pkg::* for the FSM state and flag offsets.
package pkt_marker_pkg;

  typedef enum logic [0:0] {
    PASS    = 1'b0,
    DISCARD = 1'b1
  } pkt_state_e;

  // Flag bit positions counted down from the MSB of the output word
  localparam int TUSER_OFS  = 1;
  localparam int TLAST_OFS  = 2;

  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/pkt_error_marker_if.sv
// Upstream beat stream plus downstream FIFO write port of the error marker.
// master drives beats into the marker, slave is the marker itself.
interface pkt_error_marker_if #(
  parameter int D_WIDTH = 6
);

  logic [D_WIDTH-3:0] up_data;
  logic               up_last;
  logic               up_err;
  logic               up_valid;
  logic               up_ready;
  logic [D_WIDTH-1:0] down_data;
  logic               down_valid;
  logic               down_ready;

  modport master (
    output up_data, up_last, up_err, up_valid, down_ready,
    input  up_ready, down_data, down_valid
  );

  modport slave (
    input  up_data, up_last, up_err, up_valid, down_ready,
    output up_ready, down_data, down_valid
  );

endinterface

// File: rtl/pkt_error_marker_out_reg.sv
// Single-entry valid/ready output register with full throughput:
// a pop and a push in the same cycle reload the register directly.
module pkt_out_reg #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  // rst_n term keeps the upstream stalled for the whole reset window
  assign in_ready = rst_n & (~out_valid | out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pkt_error_marker.sv
// Packet qualification ahead of the rollback FIFO: marks errored/oversize packets
// with tuser on tlast. Optional XOR checksum on the last beat via PKT_XOR_CHECK_EN.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   PASS    | beats forwarded, length/error/checksum accumulated
//   DISCARD | oversize remainder swallowed until its last beat
module pkt_error_marker
  import pkt_marker_pkg::*;
#(
  parameter int D_WIDTH   = 6,
  parameter int MAX_BEATS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pkt_error_marker_if.slave     bus,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int PW = D_WIDTH - 2;
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  pkt_state_e         state, state_nxt;
  logic [CW-1:0]      beat_cnt, beat_cnt_nxt;
  logic               err_acc, err_acc_nxt;
  logic               chk_fail;
  logic               at_limit;
  logic               accept;
  logic               push_valid;
  logic               push_ready;
  logic [D_WIDTH-1:0] push_data;

`ifdef PKT_XOR_CHECK_EN
  logic [PW-1:0]      xor_acc, xor_acc_nxt;

  assign chk_fail = (bus.up_data != xor_acc);
`else
  assign chk_fail = 1'b0;
`endif

  assign bus.up_ready = (state == DISCARD) ? rst_n : push_ready;
  assign accept       = bus.up_valid & bus.up_ready;
  assign at_limit     = (beat_cnt == CW'(MAX_BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PASS;
      beat_cnt <= '0;
      err_acc  <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      err_acc  <= err_acc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    err_acc_nxt  = err_acc;
    push_valid   = 1'b0;
    push_data    = '0;

    if (state == PASS) begin
      push_valid          = bus.up_valid;
      push_data[PW-1:0]   = bus.up_data;
      if (bus.up_last) begin
        push_data[D_WIDTH-TUSER_OFS] = err_acc | bus.up_err | chk_fail;
        push_data[D_WIDTH-TLAST_OFS] = 1'b1;
      end else if (at_limit) begin
        // forced truncation closes the packet as bad
        push_data[D_WIDTH-TUSER_OFS] = 1'b1;
        push_data[D_WIDTH-TLAST_OFS] = 1'b1;
      end

      if (accept) begin
        if (bus.up_last || at_limit) begin
          beat_cnt_nxt = '0;
          err_acc_nxt  = 1'b0;
          if (!bus.up_last) begin
            state_nxt = DISCARD;
          end
        end else begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          err_acc_nxt  = err_acc | bus.up_err;
        end
      end
    end else if (accept && bus.up_last) begin
      state_nxt = PASS;
    end
  end

`ifdef PKT_XOR_CHECK_EN
  always_comb begin
    xor_acc_nxt = xor_acc;
    if (state == PASS && accept) begin
      if (bus.up_last || at_limit) begin
        xor_acc_nxt = '0;
      end else begin
        xor_acc_nxt = xor_acc ^ bus.up_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_acc <= '0;
    end else begin
      xor_acc <= xor_acc_nxt;
    end
  end
`endif

  pkt_out_reg #(
    .W (D_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (push_valid),
    .in_data   (push_data),
    .in_ready  (push_ready),
    .out_valid (bus.down_valid),
    .out_data  (bus.down_data),
    .out_ready (bus.down_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (bus.down_valid && bus.down_ready &&
                 bus.down_data[D_WIDTH-TUSER_OFS] && drop_cnt != DROP_MAX) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pkt_error_marker.sv
// Self-checking bench for pkt_error_marker (D_WIDTH=6, MAX_BEATS=6): spec vectors,
// hand-written timing sequences and random packets against a packet-level model.
module tb_pkt_error_marker;

  localparam int DW = 6;
  localparam int MB = 6;

  logic       clk;
  logic       rst_n;
  logic [7:0] drop_cnt;

  pkt_error_marker_if #(.D_WIDTH(DW)) bus ();

  pkt_error_marker #(
    .D_WIDTH   (DW),
    .MAX_BEATS (MB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 0: ready, 1: toggle, 2: random, 3: held low
  int   rdy_mode = 0;
  logic rdy_tog  = 1'b0;

  initial begin
    bus.down_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      rdy_tog = ~rdy_tog;
      case (rdy_mode)
        1:       bus.down_ready = rdy_tog;
        2:       bus.down_ready = ($urandom_range(0, 3) != 0);
        3:       bus.down_ready = 1'b0;
        default: bus.down_ready = 1'b1;
      endcase
    end
  end

  logic [5:0] act_q[$];
  logic [5:0] exp_q[$];
  logic [3:0] cur_d[$];
  logic       cur_e[$];
  int         exp_drop = 0;

  always @(negedge clk) begin
    if (rst_n && bus.down_valid && bus.down_ready) act_q.push_back(bus.down_data);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Packet-level reference: expected output words derived from a whole accepted packet
  task automatic model_beat(input logic [3:0] d, input logic l, input logic e);
    int         n;
    logic       bad;
    logic [3:0] x;
    cur_d.push_back(d);
    cur_e.push_back(e);
    if (l) begin
      n   = cur_d.size();
      bad = 1'b0;
      x   = 4'h0;
      if (n > MB) begin
        for (int i = 0; i < MB - 1; i++) exp_q.push_back({2'b00, cur_d[i]});
        exp_q.push_back({2'b11, cur_d[MB-1]});
        if (exp_drop < 255) exp_drop++;
      end else begin
        for (int i = 0; i < n - 1; i++) begin
          exp_q.push_back({2'b00, cur_d[i]});
          x   = x ^ cur_d[i];
          bad = bad | cur_e[i];
        end
        bad = bad | cur_e[n-1];
`ifdef PKT_XOR_CHECK_EN
        if (cur_d[n-1] != x) bad = 1'b1;
`endif
        exp_q.push_back({bad, 1'b1, cur_d[n-1]});
        if (bad && exp_drop < 255) exp_drop++;
      end
      cur_d.delete();
      cur_e.delete();
    end
  endtask

  task automatic send_beat(input logic [3:0] d, input logic l, input logic e);
    logic acc;
    bit   done;
    done = 0;
    bus.up_data  = d;
    bus.up_last  = l;
    bus.up_err   = e;
    bus.up_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      acc = bus.up_ready;
      @(posedge clk);
      #1;
      if (acc) done = 1;
    end
    if (done) model_beat(d, l, e);
    else chk("send_beat timeout", 0, 1);
  endtask

  task automatic idle();
    bus.up_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit empty;
    empty = 0;
    bus.up_valid = 1'b0;
    rdy_mode     = 0;
    for (int i = 0; i < 20 && !empty; i++) begin
      @(negedge clk);
      if (!bus.down_valid) empty = 1;
    end
    if (!empty) chk("drain timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string name);
    chk({name, " count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk({name, " word"}, int'(act_q[i]), int'(exp_q[i]));
    chk({name, " drop_cnt"}, int'(drop_cnt), exp_drop);
    act_q.delete();
    exp_q.delete();
  endtask

  typedef struct packed {
    logic [3:0]       len;
    logic [8:0][3:0]  d;
    logic [8:0]       err;
    logic [3:0]       n_out;
    logic [5:0][7:0]  exp;
    logic             drop;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int         tbl_drop;
    int         len;
    logic [3:0] d, x;
    logic       l;

    tbl[0] = '{len: 3, d: 36'h653,      err: 9'h000, n_out: 3, exp: 48'h160503,       drop: 1'b0};
`ifdef PKT_XOR_CHECK_EN
    tbl[1] = '{len: 3, d: 36'h753,      err: 9'h000, n_out: 3, exp: 48'h370503,       drop: 1'b1};
    tbl[7] = '{len: 1, d: 36'h5,        err: 9'h000, n_out: 1, exp: 48'h35,           drop: 1'b1};
`else
    tbl[1] = '{len: 3, d: 36'h753,      err: 9'h000, n_out: 3, exp: 48'h170503,       drop: 1'b0};
    tbl[7] = '{len: 1, d: 36'h5,        err: 9'h000, n_out: 1, exp: 48'h15,           drop: 1'b0};
`endif
    tbl[2] = '{len: 4, d: 36'h0321,     err: 9'h002, n_out: 4, exp: 48'h30030201,     drop: 1'b1};
    tbl[3] = '{len: 8, d: 36'h87654321, err: 9'h040, n_out: 6, exp: 48'h360504030201, drop: 1'b1};
    tbl[4] = '{len: 3, d: 36'h642,      err: 9'h000, n_out: 3, exp: 48'h160402,       drop: 1'b0};
    tbl[5] = '{len: 6, d: 36'h154321,   err: 9'h000, n_out: 6, exp: 48'h110504030201, drop: 1'b0};
    tbl[6] = '{len: 1, d: 36'h0,        err: 9'h000, n_out: 1, exp: 48'h10,           drop: 1'b0};

    bus.up_data  = '0;
    bus.up_last  = 1'b0;
    bus.up_err   = 1'b0;
    bus.up_valid = 1'b0;
    rst_n        = 1'b0;

    #3;
    chk("reset down_valid", int'(bus.down_valid), 0);
    chk("reset down_data", int'(bus.down_data), 0);
    chk("reset drop_cnt", int'(drop_cnt), 0);
    chk("reset up_ready", int'(bus.up_ready), 0);
    #17;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // one-cycle latency from accept to down_valid
    send_beat(4'h3, 1'b0, 1'b0);
    chk("latency valid", int'(bus.down_valid), 1);
    chk("latency data", int'(bus.down_data), 'h03);
    send_beat(4'h5, 1'b0, 1'b0);
    send_beat(4'h6, 1'b1, 1'b0);
    drain();
    check_stream("good pkt");

    // five-cycle stall with a beat waiting upstream
    send_beat(4'h3, 1'b0, 1'b0);
    rdy_mode     = 3;
    bus.up_data  = 4'h5;
    bus.up_last  = 1'b0;
    bus.up_err   = 1'b0;
    bus.up_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall up_ready", int'(bus.up_ready), 0);
      chk("stall down_valid", int'(bus.down_valid), 1);
      chk("stall down_data", int'(bus.down_data), 'h03);
    end
    rdy_mode = 0;
    send_beat(4'h5, 1'b0, 1'b0);
    send_beat(4'h6, 1'b1, 1'b0);
    drain();
    check_stream("stall");

    tbl_drop = exp_drop;
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < int'(tbl[v].len); i++)
        send_beat(tbl[v].d[i], (i == int'(tbl[v].len) - 1), tbl[v].err[i]);
      drain();
      if (tbl[v].drop) tbl_drop++;
      chk($sformatf("vec%0d count", v), act_q.size(), int'(tbl[v].n_out));
      for (int j = 0; j < int'(tbl[v].n_out) && j < act_q.size(); j++)
        chk($sformatf("vec%0d word%0d", v, j), int'(act_q[j]), int'(tbl[v].exp[j]));
      chk($sformatf("vec%0d drop_cnt", v), int'(drop_cnt), tbl_drop);
      act_q.delete();
      exp_q.delete();
    end

    // toggling downstream ready
    rdy_mode = 1;
    send_beat(4'h1, 1'b0, 1'b0);
    send_beat(4'h2, 1'b0, 1'b0);
    send_beat(4'h3, 1'b0, 1'b0);
    send_beat(4'h4, 1'b0, 1'b0);
    send_beat(4'h5, 1'b0, 1'b0);
    send_beat(4'h1, 1'b1, 1'b0);
    send_beat(4'h7, 1'b0, 1'b0);
    send_beat(4'h7, 1'b1, 1'b0);
    drain();
    check_stream("toggle");

    // reset mid-packet after an errored beat
    send_beat(4'h1, 1'b0, 1'b0);
    send_beat(4'h2, 1'b0, 1'b1);
    bus.up_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst down_valid", int'(bus.down_valid), 0);
    chk("async rst down_data", int'(bus.down_data), 0);
    chk("async rst up_ready", int'(bus.up_ready), 0);
    chk("async rst drop_cnt", int'(drop_cnt), 0);
    act_q.delete();
    exp_q.delete();
    cur_d.delete();
    cur_e.delete();
    exp_drop = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(4'h4, 1'b0, 1'b0);
    send_beat(4'h1, 1'b0, 1'b0);
    send_beat(4'h2, 1'b0, 1'b0);
    send_beat(4'h3, 1'b0, 1'b0);
    send_beat(4'h4, 1'b1, 1'b0);
    drain();
    check_stream("after reset");

    // random packets under random backpressure
    rdy_mode = 2;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 9);
      x   = 4'h0;
      for (int i = 0; i < len; i++) begin
        d = 4'($urandom);
        l = (i == len - 1);
        if (l && $urandom_range(0, 2) != 0) d = x;
        if (!l) x = x ^ d;
        send_beat(d, l, ($urandom_range(0, 9) == 0));
        if ($urandom_range(0, 4) == 0) idle();
      end
    end
    drain();
    check_stream("random");

    // drop counter saturation
    for (int p = 0; p < 260; p++) send_beat(4'h0, 1'b1, 1'b1);
    drain();
    check_stream("saturate");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
